// File: rtl/input_devices.sv
// Purpose : read-only I/O port block exposing two 32-bit device words, a device count and
//           optional sticky per-bit change flags (macro INPUT_DEVICES_CHANGE_DETECT_EN).
// Latency : read data is combinational (0 cycles); change flags update on the rising clk edge.
// Backpressure: none; reads are always served, ack clears the addressed flag word in one edge.
module input_devices (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        ack,
    input  logic [31:0] device0_values,
    input  logic [31:0] device1_values,
    output logic [31:0] value
);

    localparam logic [15:0] ADDR_DEV0  = 16'h0000;
    localparam logic [15:0] ADDR_DEV1  = 16'h0001;
    localparam logic [15:0] ADDR_CHG0  = 16'h0002;
    localparam logic [15:0] ADDR_CHG1  = 16'h0003;
    localparam logic [15:0] ADDR_COUNT = 16'h0004;
    localparam logic [31:0] DEV_COUNT  = 32'h0000_0002;

    logic [31:0] chg0_view;
    logic [31:0] chg1_view;

`ifdef INPUT_DEVICES_CHANGE_DETECT_EN
    logic [31:0] prev0;
    logic [31:0] prev1;
    logic [31:0] chg0;
    logic [31:0] chg1;
    logic [31:0] clr0;
    logic [31:0] clr1;

    // Clear masks: ack only acts on the flag word currently addressed.
    always_comb begin
        clr0 = (ack && (address == ADDR_CHG0)) ? 32'hFFFF_FFFF : 32'h0000_0000;
        clr1 = (ack && (address == ADDR_CHG1)) ? 32'hFFFF_FFFF : 32'h0000_0000;
    end

    // Sample inputs each edge; new toggles are ORed in after the clear so they win.
    always_ff @(posedge clk) begin
        if (reset) begin
            chg0  <= 32'h0000_0000;
            chg1  <= 32'h0000_0000;
            prev0 <= device0_values;
            prev1 <= device1_values;
        end else begin
            chg0  <= (chg0 & ~clr0) | (device0_values ^ prev0);
            chg1  <= (chg1 & ~clr1) | (device1_values ^ prev1);
            prev0 <= device0_values;
            prev1 <= device1_values;
        end
    end

    assign chg0_view = chg0;
    assign chg1_view = chg1;
`else
    // Without change detection the clock, reset and ack have nothing to drive.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk, reset, ack};

    assign chg0_view = 32'h0000_0000;
    assign chg1_view = 32'h0000_0000;
`endif

    // Fully decoded read mux; unmapped addresses return zero.
    always_comb begin
        value = 32'h0000_0000;
        case (address)
            ADDR_DEV0:  value = device0_values;
            ADDR_DEV1:  value = device1_values;
            ADDR_CHG0:  value = chg0_view;
            ADDR_CHG1:  value = chg1_view;
            ADDR_COUNT: value = DEV_COUNT;
            default:    value = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_input_devices.sv
module tb_input_devices;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [31:0] device0_values = 32'h0;
    logic [31:0] device1_values = 32'h0;
    logic [31:0] value;

    bit clk_run = 1'b0;
    int errors = 0;
    int checks = 0;

    input_devices dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .ack(ack),
        .device0_values(device0_values),
        .device1_values(device1_values),
        .value(value)
    );

    always #5 if (clk_run) clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] exp;
    } vec_t;

    // Reference model state for the change flags (only meaningful with the feature built in).
    logic [31:0] m_prev [2];
    logic [31:0] m_chg  [2];

    task automatic check(input string name, input logic [31:0] exp);
        checks++;
        if (value !== exp) begin
            errors++;
            $display("FAIL %s: value=%h expected=%h (addr=%h t=%0t)", name, value, exp, address, $time);
        end
    endtask

    task automatic edge_clk();
        @(posedge clk);
        #1;
    endtask

    // Expected read data from the address map.
    function automatic logic [31:0] ref_read(input logic [15:0] a, input logic [31:0] d0,
                                             input logic [31:0] d1, input logic [31:0] c0,
                                             input logic [31:0] c1);
        if (a == 16'd0) return d0;
        if (a == 16'd1) return d1;
        if (a == 16'd2) return c0;
        if (a == 16'd3) return c1;
        if (a == 16'd4) return 32'd2;
        return 32'd0;
    endfunction

    // Advance the model by one edge using the current inputs.
    task automatic model_edge();
        logic [31:0] dv [2];
        dv[0] = device0_values;
        dv[1] = device1_values;
        for (int n = 0; n < 2; n++) begin
            if (reset) begin
                m_chg[n] = 32'd0;
            end else begin
                for (int b = 0; b < 32; b++) begin
                    bit cleared;
                    cleared = ack && (address == 16'(n + 2));
                    m_chg[n][b] = (m_chg[n][b] && !cleared) || (dv[n][b] != m_prev[n][b]);
                end
            end
            m_prev[n] = dv[n];
        end
    endtask

    vec_t vecs [$];

    initial begin
        // ---------------- table-driven read-path vectors, no clock ----------------
        vecs.push_back('{16'h0000, 32'hE5F8_4AB1, 32'h5C8C_6A01, 32'hE5F8_4AB1});
        vecs.push_back('{16'h0001, 32'hE5F8_4AB1, 32'h5C8C_6A01, 32'h5C8C_6A01});
        vecs.push_back('{16'h0004, 32'hE5F8_4AB1, 32'h5C8C_6A01, 32'h0000_0002});
        vecs.push_back('{16'h0005, 32'hE5F8_4AB1, 32'h5C8C_6A01, 32'h0000_0000});
        vecs.push_back('{16'h0100, 32'hE5F8_4AB1, 32'h5C8C_6A01, 32'h0000_0000});
        vecs.push_back('{16'hFFFF, 32'hE5F8_4AB1, 32'h5C8C_6A01, 32'h0000_0000});
        vecs.push_back('{16'h0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{16'h0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{16'h8004, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000});
`ifndef INPUT_DEVICES_CHANGE_DETECT_EN
        vecs.push_back('{16'h0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{16'h0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            address        = vecs[i].addr;
            device0_values = vecs[i].d0;
            device1_values = vecs[i].d1;
            #10;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // ---------------- random read path, no clock ----------------
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0: a = 16'd0;
                1: a = 16'd1;
                2: a = 16'd4;
                default: begin
                    a = 16'($urandom);
                    if (a == 16'd2 || a == 16'd3) a = 16'd9;
                end
            endcase
            address        = a;
            device0_values = $urandom;
            device1_values = $urandom;
            #3;
            check("rand_read", ref_read(a, device0_values, device1_values, 32'd0, 32'd0));
        end

        clk_run = 1'b1;
        address = 16'd0;
        device0_values = 32'hE5F8_4AB1;
        device1_values = 32'h5C8C_6A01;
        #2;

`ifdef INPUT_DEVICES_CHANGE_DETECT_EN
        // ---------------- feature on: directed sequences ----------------
        reset = 1'b1;
        edge_clk();
        reset = 1'b0;
        edge_clk();
        address = 16'd2; #1; check("reset_chg0", 32'h0);
        address = 16'd3; #1; check("reset_chg1", 32'h0);

        device0_values = device0_values ^ 32'h8000_0001;
        edge_clk();
        address = 16'd2; #1; check("flip_chg0", 32'h8000_0001);
        address = 16'd3; #1; check("flip_chg1", 32'h0);

        address = 16'd2; ack = 1'b1;
        edge_clk();
        ack = 1'b0; #1; check("ack_clear", 32'h0);

        device0_values = device0_values ^ 32'h8000_0001;
        edge_clk();
        #1; check("reflag", 32'h8000_0001);
        ack = 1'b1;
        device0_values = device0_values ^ 32'h0000_0010;
        edge_clk();
        ack = 1'b0; #1; check("clear_vs_change", 32'h0000_0010);

        address = 16'd3; ack = 1'b1;
        edge_clk();
        ack = 1'b0;
        address = 16'd2; #1; check("ack_other_dev", 32'h0000_0010);

        device0_values = device0_values ^ 32'hFFFF_0000;
        device1_values = device1_values ^ 32'h0000_0001;
        reset = 1'b1;
        edge_clk();
        reset = 1'b0;
        address = 16'd2; #1; check("midreset_chg0", 32'h0);
        address = 16'd3; #1; check("midreset_chg1", 32'h0);
        edge_clk();
        address = 16'd2; #1; check("postreset_chg0", 32'h0);
        address = 16'd3; #1; check("postreset_chg1", 32'h0);

        // ---------------- feature on: randomized against model ----------------
        m_prev[0] = device0_values;
        m_prev[1] = device1_values;
        m_chg[0]  = 32'd0;
        m_chg[1]  = 32'd0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] mask0, mask1;
            mask0 = $urandom & $urandom & $urandom;
            mask1 = $urandom & $urandom & $urandom;
            device0_values = device0_values ^ (($urandom_range(0, 2) == 0) ? mask0 : 32'd0);
            device1_values = device1_values ^ (($urandom_range(0, 2) == 0) ? mask1 : 32'd0);
            address = 16'($urandom_range(0, 5));
            ack     = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 40) == 0);
            model_edge();
            edge_clk();
            reset = 1'b0;
            ack   = 1'b0;
            address = 16'($urandom_range(0, 5));
            #1;
            check("rand_model", ref_read(address, device0_values, device1_values, m_chg[0], m_chg[1]));
        end
`else
        // ---------------- feature off: flags never appear ----------------
        for (int i = 0; i < 3; i++) begin
            device0_values = $urandom;
            device1_values = $urandom;
            ack = 1'b1;
            address = 16'd2;
            edge_clk();
            ack = 1'b0;
            address = 16'd2; #1; check("off_chg0", 32'h0);
            address = 16'd3; #1; check("off_chg1", 32'h0);
            address = 16'd0; #1; check("off_dev0", device0_values);
            address = 16'd1; #1; check("off_dev1", device1_values);
        end
`endif

        clk_run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
